// File: rtl/result_collector_c_if.sv
// Write-side bundle of the result collector: skewed result beats in, de-skewed
// rows out to the memory path with a valid/ready handshake.
interface result_collector_c_if #(
  parameter int data_width = 32,
  parameter int bus_width  = 64
);
  localparam int MAX_DIM = bus_width / data_width;

  logic                          vectorC_valid;
  logic [data_width*MAX_DIM-1:0] vectorC;
  logic                          write_ready;
  logic                          write_enable_C;
  logic [7:0]                    row_index;
  logic [bus_width-1:0]          bus;

  modport slave (
    input  vectorC_valid, vectorC, write_ready,
    output write_enable_C, row_index, bus
  );

  modport master (
    output vectorC_valid, vectorC, write_ready,
    input  write_enable_C, row_index, bus
  );
endinterface

// File: rtl/result_collector_c.sv
// De-skews diagonal result beats from the systolic array into a square matrix C
// and writes it back one row per bus beat, then pulses done_collect_C.
module result_collector_c #(
  parameter int data_width = 32,
  parameter int bus_width  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       abort,
  input  logic                       start_collect,
  result_collector_c_if.slave        vif,
  output logic                       busy,
  output logic                       done_collect_C,
  output logic                       seq_err
);
  localparam int MAX_DIM = bus_width / data_width;
  localparam int TW      = $clog2(2 * MAX_DIM);
  localparam int RW      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam logic [TW-1:0] LAST_T = TW'(2 * MAX_DIM - 2);
  localparam logic [RW-1:0] LAST_R = RW'(MAX_DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WRITE, S_DONE} state_e;

  state_e               state_q;
  logic [TW-1:0]        t_q;
  logic [RW-1:0]        row_q;
  logic                 we_q, busy_q, done_q, err_q;
  logic [7:0]           row_index_q;
  logic [bus_width-1:0] bus_q;
  logic [data_width-1:0] mat_q [MAX_DIM][MAX_DIM];

  // Beat t carries element C[r][j] on lane j exactly when r + j == t.
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE && vif.vectorC_valid) begin
      for (int r = 0; r < MAX_DIM; r++)
        for (int j = 0; j < MAX_DIM; j++)
          if (t_q == TW'(r + j))
            mat_q[r][j] <= vif.vectorC[data_width*j +: data_width];
    end
  end

  function automatic logic [bus_width-1:0] pack_row(input logic [RW-1:0] r);
    logic [bus_width-1:0] v;
    v = '0;
    for (int k = 0; k < MAX_DIM; k++) v[data_width*k +: data_width] = mat_q[r][k];
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset || abort) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      row_q       <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      row_index_q <= '0;
      bus_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_collect) begin
            state_q <= S_CAPTURE;
            t_q     <= '0;
            busy_q  <= 1'b1;
            err_q   <= vif.vectorC_valid;
          end else if (vif.vectorC_valid) begin
            err_q <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (vif.vectorC_valid) begin
            if (t_q == LAST_T) begin
              // Row 0 is already complete before the last beat lands.
              state_q     <= S_WRITE;
              row_q       <= '0;
              we_q        <= 1'b1;
              row_index_q <= '0;
              bus_q       <= pack_row('0);
            end else begin
              t_q <= t_q + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (vif.vectorC_valid) err_q <= 1'b1;
          if (vif.write_ready) begin
            if (row_q == LAST_R) begin
              state_q     <= S_DONE;
              we_q        <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              row_index_q <= '0;
              bus_q       <= '0;
            end else begin
              row_q       <= row_q + 1'b1;
              row_index_q <= 8'(row_q) + 8'd1;
              bus_q       <= pack_row(row_q + 1'b1);
            end
          end
        end
        S_DONE: begin
          if (vif.vectorC_valid) err_q <= 1'b1;
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vif.write_enable_C = we_q;
  assign vif.row_index      = row_index_q;
  assign vif.bus            = bus_q;
  assign busy               = busy_q;
  assign done_collect_C     = done_q;
  assign seq_err            = err_q;
endmodule

// File: doc/result_collector_c.md
Name: result_collector_c

Overview:
- Output-side counterpart of the operand-B skew/feed stage.
- Accepts the diagonally skewed result vectors leaving the systolic array and de-skews them into a max_dim x max_dim result matrix C.
- Writes C back to memory one row per bus beat, using a valid/ready handshake, then pulses a completion flag.
- Sits between the systolic array output and the memory/APB write path.

Parameters:
- data_width, 32, width of one matrix element.
- bus_width, 64, memory bus width. Local max_dim = bus_width/data_width; only integer max_dim >= 2 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- abort  in  1  synchronous clear to IDLE; same effect as reset, lower priority.
- start_collect  in  1  begins a capture; honoured only in IDLE.
- vectorC_valid  in  1  vectorC carries a skewed beat this cycle.
- vectorC  in  data_width*max_dim  lane j at [data_width*(j+1)-1 : data_width*j].
- write_ready  in  1  memory accepts the current row.
- write_enable_C  out  1  row on bus is valid.
- row_index  out  8  index of the row on bus (0..max_dim-1).
- bus  out  bus_width  row data; lane k = C[row][k] at [data_width*(k+1)-1 : data_width*k].
- busy  out  1  high in CAPTURE and WRITE.
- done_collect_C  out  1  one-cycle completion pulse.
- seq_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset==0 at posedge), or abort==1 with reset==1:
  - State goes to IDLE; beat and row counters clear to 0.
  - All outputs go to 0 next cycle: write_enable_C, row_index, bus, busy, done_collect_C, seq_err.
  - Matrix storage is not cleared but is never emitted without a new capture.
  - Applies from any state, including mid-capture and mid-write.
- States: IDLE -> CAPTURE -> WRITE -> DONE -> IDLE.
- IDLE:
  - start_collect==1 moves to CAPTURE; beat counter t=0; seq_err clears.
  - A vectorC_valid in that same cycle is not captured and sets seq_err.
- CAPTURE:
  - Each cycle with vectorC_valid==1 is one beat t, for t = 0 .. 2*max_dim-2.
  - For each lane j with 0 <= t-j < max_dim, store C[t-j][j] = lane j. Other lanes are ignored.
  - t increments only on valid beats; gaps of any length are allowed.
  - start_collect is ignored.
  - The beat t = 2*max_dim-2 moves to WRITE with row=0.
- WRITE:
  - write_enable_C=1, row_index=row, bus = packed row C[row].
  - A row transfers when write_enable_C && write_ready. row, bus and row_index are held stable while write_ready==0.
  - The transfer of row max_dim-1 moves to DONE.
  - vectorC_valid==1 sets seq_err; the data is ignored.
- DONE:
  - done_collect_C=1 for exactly one cycle; write_enable_C=0; next state IDLE.
  - vectorC_valid==1 sets seq_err.
- Latency (write_ready held high): final beat accepted in cycle N.
  - write_enable_C rises with row 0 in cycle N+1.
  - Row r appears in cycle N+1+r.
  - done_collect_C is high in cycle N+1+max_dim.
- busy is a registered decode of state; done_collect_C and busy are never high together.
- Storage arrays are plain registers; no arithmetic is performed on data; counters saturate by state exit, never wrap.

Test Plan (defaults, max_dim=2):
- Basic: reset; start_collect; beats {lane1,lane0} = {0,1}, {2,3}, {4,0}; write_ready=1.
  -> bus 64'h00000002_00000001 with row_index 0, then 64'h00000004_00000003 with row_index 1, then done_collect_C for one cycle; seq_err=0.
- Gapped beats: same data with 3 idle cycles between each beat -> identical bus output; busy stays high throughout capture.
- Backpressure: write_ready=0 for 4 cycles while row 0 is presented -> bus and row_index held at row 0, no advance; row 1 appears the cycle after write_ready rises.
- Protocol error: vectorC_valid pulsed in IDLE, then a normal capture.
  -> seq_err=1 after the stray pulse; cleared on start_collect; result unaffected.
- Reset mid-write: drive reset=0 during row 0 stall -> next cycle all outputs 0, state IDLE, no done_collect_C.
  -> A new full capture then produces correct rows.
- Abort mid-capture: abort after beat 1 -> IDLE, busy=0.
  -> A restart with C = [[5,6],[7,8]] yields 64'h00000006_00000005, then 64'h00000008_00000007.
